// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one multi-cycle memory port between instruction fetch (i_*) and
//   data access (d_*). Round-robin grant on ties, IDLE -> BUSY -> RESP
//   sequencing, one-cycle ack with read data, optional ready timeout.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   i_req/i_addr            fetch request (held until i_ack)
//   i_rdata/i_ack/i_err     fetch response (valid while i_ack)
//   d_req/d_we/d_addr/d_wdata  data request (held until d_ack)
//   d_rdata/d_ack/d_err     data response (valid while d_ack)
//   mem_req/mem_we/mem_addr/mem_wdata  latched memory transaction
//   mem_rdata/mem_ready     memory completion
//   stall                   any request still waiting for its ack
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  d_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  stall
);

  // counter only needs to reach TIMEOUT-1
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_nxt;
  logic          gnt_d;    // current transfer belongs to the data port
  logic          last_d;   // last grant went to the data port
  logic          pick_d;
  logic          grant, done_ok, done_to;
  logic [CW-1:0] cnt;

  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    // data wins only if fetch is idle or fetch had the previous grant
    pick_d    = d_req & (~i_req | ~last_d);
    case (state)
      IDLE: if (i_req | d_req) begin
        grant     = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (mem_ready) begin
        done_ok   = 1'b1;
        state_nxt = RESP;
      end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
        done_to   = 1'b1;
        state_nxt = RESP;
      end
      // requests are not sampled here, so a held req is never served twice
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_d     <= 1'b0;
      last_d    <= 1'b1;   // first tie goes to fetch
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_err     <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      // acks/errs are single-cycle: set on completion, cleared otherwise
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      i_err <= 1'b0;
      d_err <= 1'b0;

      if (grant) begin
        gnt_d    <= pick_d;
        last_d   <= pick_d;
        cnt      <= '0;
        mem_req  <= 1'b1;
        mem_we   <= pick_d & d_we;
        mem_addr <= pick_d ? d_addr : i_addr;
        if (pick_d) mem_wdata <= d_wdata;
      end

      if (state == BUSY) cnt <= cnt + CW'(1);
      if (state == RESP) cnt <= '0;

      if (done_ok | done_to) begin
        mem_req <= 1'b0;
        if (gnt_d) begin
          d_ack   <= 1'b1;
          d_err   <= done_to;
          d_rdata <= (done_ok & ~mem_we) ? mem_rdata : '0;
        end else begin
          i_ack   <= 1'b1;
          i_err   <= done_to;
          i_rdata <= done_ok ? mem_rdata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_ack, i_err, d_ack, d_err, mem_req, mem_we, stall;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;     // BUSY cycles with mem_ready=0 before the final cycle
    logic        rdy;       // mem_ready on the final BUSY cycle
    logic [31:0] rd;        // mem_rdata on the final BUSY cycle
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_xfer(input vec_t v);
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    chk("grant_req", mem_req, 1);
    chk("grant_we", mem_we, v.is_d & v.we);
    chk("grant_addr", mem_addr, v.addr);
    if (v.is_d && v.we) chk("grant_wdata", mem_wdata, v.wdata);
    for (int k = 0; k < v.waits; k++) begin
      mem_ready = 1'b0;
      mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("busy_req", mem_req, 1);
      chk("busy_addr", mem_addr, v.addr);
      chk("busy_we", mem_we, v.is_d & v.we);
      if (v.is_d && v.we) chk("busy_wdata", mem_wdata, v.wdata);
      chk("busy_stall", stall, 1);
      chk("busy_noack", i_ack | d_ack, 0);
    end
    mem_ready = v.rdy;
    mem_rdata = v.rd;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("resp_req", mem_req, 0);
    chk("resp_ack", v.is_d ? d_ack : i_ack, 1);
    chk("resp_other_ack", v.is_d ? i_ack : d_ack, 0);
    chk("resp_err", v.is_d ? d_err : i_err, v.exp_err);
    chk("resp_other_err", v.is_d ? i_err : d_err, 0);
    chk("resp_rdata", v.is_d ? d_rdata : i_rdata, v.exp_rdata);
    if (v.is_d) d_req = 1'b0; else i_req = 1'b0;
    @(negedge clk);
    chk("after_ack", i_ack | d_ack, 0);
    chk("after_stall", stall, 0);
    chk("rdata_hold", v.is_d ? d_rdata : i_rdata, v.exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

    //          is_d we  addr          wdata          waits rdy rd             err  exp_rdata
    vecs[0] = '{1'b0, 1'b0, 32'h4,   32'h0,         0, 1'b1, 32'h2010_0004, 1'b0, 32'h2010_0004};
    vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 3, 1'b1, 32'h1234_5678, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h200, 32'h0,         1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b0, 32'h300, 32'h0,         3, 1'b0, 32'h0000_0055, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h8,   32'h0,         0, 1'b1, 32'h0BAD_C0DE, 1'b0, 32'h0BAD_C0DE};
    vecs[5] = '{1'b0, 1'b0, 32'hC,   32'h0,         2, 1'b1, 32'h1111_2222, 1'b0, 32'h1111_2222};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_acks", {i_ack, d_ack, i_err, d_err}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_stall", stall, 0);
    reset_n = 1'b1;

    foreach (vecs[n]) do_xfer(vecs[n]);

    // mem_ready while IDLE
    @(negedge clk);
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("idle_ready_req", mem_req, 0);
      chk("idle_ready_ack", i_ack | d_ack, 0);
    end
    mem_ready = 1'b0;

    // mem_ready held through RESP and the following IDLE
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    chk("late_grant", mem_req, 1);
    mem_ready = 1'b1; mem_rdata = 32'h77;
    @(negedge clk);
    chk("late_ack", i_ack, 1);
    mem_rdata = 32'h99;
    i_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("late_no_ack", i_ack | d_ack, 0);
      chk("late_no_req", mem_req, 0);
      chk("late_rdata", i_rdata, 32'h77);
    end
    mem_ready = 1'b0;

    // reset in the middle of a fetch (last grant is I before reset)
    i_req = 1'b1; i_addr = 32'h44;
    @(negedge clk);
    chk("mid_busy", mem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_ack", i_ack, 0);
    chk("mid_rst_addr", mem_addr, 0);
    i_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // contention: both requesting, expect I, D, I, D
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_addr = 32'h80; d_we = 1'b0;
    for (int t = 0; t < 4; t++) begin
      logic exp_d;
      exp_d = t[0];
      @(negedge clk);
      chk("rr_addr", mem_addr, exp_d ? 32'h80 : 32'h40);
      mem_ready = 1'b1; mem_rdata = 32'hA000_0000 + t;
      @(negedge clk);
      mem_ready = 1'b0;
      chk("rr_ack", exp_d ? d_ack : i_ack, 1);
      chk("rr_other_ack", exp_d ? i_ack : d_ack, 0);
      chk("rr_rdata", exp_d ? d_rdata : i_rdata, 32'hA000_0000 + t);
      if (exp_d) d_req = 1'b0; else i_req = 1'b0;
      @(negedge clk);
      chk("rr_ack_pulse", i_ack | d_ack, 0);
      if (exp_d) d_req = 1'b1; else i_req = 1'b1;
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
